// File: rtl/fruit_motion.sv
// fruit_motion: per-fruit trajectory generator feeding color_mapper.
// Launches a fruit from the bottom edge on a pseudo-random parabola, advances
// it once per video frame, and handles slice, miss and respawn delay.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high
//   frame_clk    vsync-derived frame level; its rising edge is the frame tick
//   launch_en    permits the respawn countdown and the launch
//   slice        blade-hit request, may arrive on any cycle
//   FruitX       box left X (10 bits)
//   FruitY       box top Y (10 bits); values >= SCREEN_H are off-screen
//   Fruit_size   box size; 0 hides the fruit
//   fruit_active high while flying or sliced
//   score_pulse  one-Clk pulse when a slice is accepted
//   miss_pulse   one-Clk pulse when an unsliced fruit leaves the bottom
module fruit_motion #(
  parameter int          SCREEN_W       = 640,
  parameter int          SCREEN_H       = 480,
  parameter int          FRUIT_SIZE     = 16,
  parameter int          LAUNCH_VY      = 28,
  parameter int          GRAVITY        = 1,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       launch_en,
  input  logic       slice,
  output logic [9:0] FruitX,
  output logic [9:0] FruitY,
  output logic [9:0] Fruit_size,
  output logic       fruit_active,
  output logic       score_pulse,
  output logic       miss_pulse
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    FLY    = 2'd1,
    SLICED = 2'd2
  } state_t;

  localparam logic signed [10:0] X_MAX      = 11'(SCREEN_W - FRUIT_SIZE);
  localparam logic signed [10:0] Y_EXIT     = 11'(SCREEN_H);
  localparam logic signed [10:0] X_BASE     = 11'sd64;
  localparam logic signed [7:0]  VY_LAUNCH  = 8'(-LAUNCH_VY);
  localparam logic signed [8:0]  GRAV       = 9'(GRAVITY);
  localparam logic signed [8:0]  VY_SAT     = 9'sd63;
  localparam logic [6:0]         CNT_RELOAD = 7'(RESPAWN_FRAMES);

  state_t             state, state_next;
  logic               frame_clk_q, tick;
  logic [15:0]        lfsr, lfsr_next;
  logic signed [10:0] x, x_next, y, y_next;
  logic signed [3:0]  vx, vx_next;
  logic signed [7:0]  vy, vy_next;
  logic [6:0]         counter, counter_next;
  logic               slice_latch, slice_latch_next;
  logic               score_next, miss_next;
  logic [9:0]         size_next;

  // Candidate motion values shared by FLY and SLICED.
  logic signed [10:0] x_try, y_try;
  logic signed [8:0]  vy_sum;
  logic signed [7:0]  vy_grav;

  assign tick = frame_clk & ~frame_clk_q;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  assign x_try   = x + {{7{vx[3]}}, vx};
  assign y_try   = y + {{3{vy[7]}}, vy};
  assign vy_sum  = {vy[7], vy} + GRAV;
  assign vy_grav = (vy_sum > VY_SAT) ? 8'sd63 : vy_sum[7:0];

  always_comb begin
    state_next       = state;
    x_next           = x;
    y_next           = y;
    vx_next          = vx;
    vy_next          = vy;
    counter_next     = counter;
    slice_latch_next = slice_latch;
    score_next       = 1'b0;
    miss_next        = 1'b0;
    size_next        = '0;

    unique case (state)
      WAIT: begin
        slice_latch_next = 1'b0;
        if (tick && launch_en) begin
          if (counter != '0) begin
            counter_next = counter - 7'd1;
          end else begin
            state_next = FLY;
            x_next     = X_BASE + signed'({2'b00, lfsr[8:0]});
            y_next     = Y_EXIT;
            vx_next    = {lfsr[11], lfsr[11:9]};
            vy_next    = VY_LAUNCH;
          end
        end
      end

      FLY: begin
        slice_latch_next = slice_latch | slice;
        if (tick) begin
          if (slice_latch) begin
            // Accepted slice freezes the fruit for this frame; it takes
            // priority over an exit that would otherwise happen now.
            state_next       = SLICED;
            score_next       = 1'b1;
            vx_next          = '0;
            slice_latch_next = 1'b0;
          end else begin
            if (x_try < 11'sd0 || x_try > X_MAX) begin
              vx_next = -vx;
            end else begin
              x_next = x_try;
            end
            y_next  = y_try;
            vy_next = vy_grav;
            // Exit only while falling, so the launch at Y = SCREEN_H is not a miss.
            if (y_try >= Y_EXIT && !vy[7]) begin
              state_next       = WAIT;
              miss_next        = 1'b1;
              counter_next     = CNT_RELOAD;
              slice_latch_next = 1'b0;
            end
          end
        end
      end

      SLICED: begin
        slice_latch_next = 1'b0;
        if (tick) begin
          y_next  = y_try;
          vy_next = vy_grav;
          if (y_try >= Y_EXIT) begin
            state_next   = WAIT;
            counter_next = CNT_RELOAD;
          end
        end
      end

      default: begin
        state_next   = WAIT;
        counter_next = CNT_RELOAD;
      end
    endcase

    unique case (state_next)
      FLY:     size_next = 10'(FRUIT_SIZE);
      SLICED:  size_next = 10'(FRUIT_SIZE / 2);
      default: size_next = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= WAIT;
      frame_clk_q  <= 1'b0;
      lfsr         <= SEED;
      x            <= '0;
      y            <= '0;
      vx           <= '0;
      vy           <= '0;
      counter      <= CNT_RELOAD;
      slice_latch  <= 1'b0;
      Fruit_size   <= '0;
      fruit_active <= 1'b0;
      score_pulse  <= 1'b0;
      miss_pulse   <= 1'b0;
    end else begin
      state        <= state_next;
      frame_clk_q  <= frame_clk;
      lfsr         <= lfsr_next;
      x            <= x_next;
      y            <= y_next;
      vx           <= vx_next;
      vy           <= vy_next;
      counter      <= counter_next;
      slice_latch  <= slice_latch_next;
      Fruit_size   <= size_next;
      fruit_active <= (state_next != WAIT);
      score_pulse  <= score_next;
      miss_pulse   <= miss_next;
    end
  end

  assign FruitX = x[9:0];
  assign FruitY = y[9:0];

endmodule

// File: tb/tb_fruit_motion.sv
// Directed bench for fruit_motion: reset, launch timing, free flight,
// wall reflection, slicing, slice-at-exit and reset during flight.
module tb_fruit_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       launch_en = 1'b0;
  logic       slice = 1'b0;
  logic [9:0] FruitX, FruitY, Fruit_size;
  logic       fruit_active, score_pulse, miss_pulse;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int          score_cnt = 0;
  int          miss_cnt = 0;

  logic [15:0]        m_lfsr;
  logic [15:0]        pre_lfsr;
  logic signed [10:0] fx;
  logic signed [3:0]  fvx;
  int                 lx, lvx, first_lx;

  fruit_motion #(
    .SCREEN_W(640), .SCREEN_H(480), .FRUIT_SIZE(16), .LAUNCH_VY(28),
    .GRAVITY(1), .RESPAWN_FRAMES(60), .SEED(16'hACE1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .launch_en(launch_en),
    .slice(slice), .FruitX(FruitX), .FruitY(FruitY), .Fruit_size(Fruit_size),
    .fruit_active(fruit_active), .score_pulse(score_pulse), .miss_pulse(miss_pulse)
  );

  always #5 Clk = ~Clk;

  // Reference Galois LFSR: taps 16'hB400, reset to 16'hACE1, steps every Clk.
  always @(posedge Clk) begin
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  always @(negedge Clk) begin
    if (score_pulse === 1'b1) score_cnt++;
    if (miss_pulse === 1'b1) miss_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Horizontal rule: step by vx unless that leaves [0, 624], then reverse vx.
  function automatic void x_step(inout int xx, inout int vv);
    int nx;
    nx = xx + vv;
    if (nx < 0 || nx > 624) vv = -vv;
    else xx = nx;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; slice = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // One frame tick; returns #1 after the tick edge. pre_lfsr holds the LFSR
  // value the design sees on the tick edge.
  task automatic tick();
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    pre_lfsr = m_lfsr;
    frame_clk = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_slice();
    @(negedge Clk); slice = 1'b1;
    @(negedge Clk); slice = 1'b0;
  endtask

  task automatic launch();
    do_reset();
    launch_en = 1'b1;
    repeat (61) tick();
    lx  = 64 + int'(pre_lfsr[8:0]);
    lvx = int'(pre_lfsr[11:9]);
    if (pre_lfsr[11]) lvx -= 8;
  endtask

  task automatic force_xv();
    @(negedge Clk);
    force dut.x = fx;
    force dut.vx = fvx;
    @(negedge Clk);
    release dut.x;
    release dut.vx;
  endtask

  task automatic test_reset();
    logic [1:0] st;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    st = dut.state;
    n_checks++;
    if ({FruitX, FruitY, Fruit_size, fruit_active, score_pulse, miss_pulse} !== 33'd0)
      $display("FAIL reset_outputs: got X=%0d Y=%0d size=%0d act=%b sc=%b miss=%b, want all 0",
               FruitX, FruitY, Fruit_size, fruit_active, score_pulse, miss_pulse);
    else n_pass++;
    n_checks++;
    if (st !== 2'd0 || dut.counter !== 7'd60 || dut.slice_latch !== 1'b0)
      $display("FAIL reset_state: got state=%0d counter=%0d latch=%b, want 0/60/0",
               st, dut.counter, dut.slice_latch);
    else n_pass++;
  endtask

  task automatic test_launch();
    do_reset();
    launch_en = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      n_checks++;
      if (Fruit_size !== 10'd0 || fruit_active !== 1'b0)
        $display("FAIL wait_hidden tick %0d: size=%0d act=%b, want 0/0", t, Fruit_size, fruit_active);
      else n_pass++;
    end
    tick();
    first_lx = 64 + int'(pre_lfsr[8:0]);
    n_checks++;
    if (FruitY !== 10'd480 || Fruit_size !== 10'd16 || fruit_active !== 1'b1)
      $display("FAIL launch_tick61: Y=%0d size=%0d act=%b, want 480/16/1", FruitY, Fruit_size, fruit_active);
    else n_pass++;
    n_checks++;
    if (FruitX !== 10'(first_lx))
      $display("FAIL launch_x: got %0d want %0d", FruitX, first_lx);
    else n_pass++;
  endtask

  task automatic test_launch_en_freeze();
    int sc0;
    do_reset();
    launch_en = 1'b0;
    sc0 = score_cnt;
    pulse_slice();
    repeat (10) tick();
    n_checks++;
    if (dut.counter !== 7'd60 || Fruit_size !== 10'd0 || dut.slice_latch !== 1'b0 || score_cnt != sc0)
      $display("FAIL freeze: counter=%0d size=%0d latch=%b scores=%0d, want 60/0/0/%0d",
               dut.counter, Fruit_size, dut.slice_latch, score_cnt, sc0);
    else n_pass++;
    launch_en = 1'b1;
    repeat (60) tick();
    n_checks++;
    if (Fruit_size !== 10'd0)
      $display("FAIL freeze_no_early_launch: size=%0d want 0", Fruit_size);
    else n_pass++;
    tick();
    n_checks++;
    if (Fruit_size !== 10'd16)
      $display("FAIL freeze_launch: size=%0d want 16", Fruit_size);
    else n_pass++;
  endtask

  task automatic test_free_flight();
    int ex, evx, ey, m0;
    launch();
    ex = lx; evx = lvx; m0 = miss_cnt;
    for (int k = 1; k <= 57; k++) begin
      tick();
      x_step(ex, evx);
      ey = 480 - 28 * k + (k * (k - 1)) / 2;
      n_checks++;
      if (FruitY !== 10'(ey) || FruitX !== 10'(ex))
        $display("FAIL flight tick %0d: X=%0d Y=%0d want X=%0d Y=%0d", k, FruitX, FruitY, ex, ey);
      else n_pass++;
      if (k == 28) begin
        n_checks++;
        if (FruitY !== 10'd74) $display("FAIL apex: Y=%0d want 74", FruitY);
        else n_pass++;
      end
      if (k < 57) begin
        n_checks++;
        if (fruit_active !== 1'b1 || miss_pulse !== 1'b0)
          $display("FAIL flight_active tick %0d: act=%b miss=%b want 1/0", k, fruit_active, miss_pulse);
        else n_pass++;
      end
    end
    n_checks++;
    if (miss_pulse !== 1'b1 || Fruit_size !== 10'd0 || fruit_active !== 1'b0)
      $display("FAIL miss_exit: miss=%b size=%0d act=%b want 1/0/0", miss_pulse, Fruit_size, fruit_active);
    else n_pass++;
    @(posedge Clk); #1;
    n_checks++;
    if (miss_pulse !== 1'b0 || miss_cnt - m0 != 1)
      $display("FAIL miss_one_clk: miss=%b count=%0d want 0/1", miss_pulse, miss_cnt - m0);
    else n_pass++;
  endtask

  task automatic test_wall();
    launch();
    tick();
    fx = 11'sd622; fvx = 4'sd3; force_xv();
    tick();
    n_checks++;
    if (FruitX !== 10'd622 || dut.vx !== -4'sd3)
      $display("FAIL wall_right_hold: X=%0d vx=%0d want 622/-3", FruitX, dut.vx);
    else n_pass++;
    tick();
    n_checks++;
    if (FruitX !== 10'd619) $display("FAIL wall_right_after: X=%0d want 619", FruitX);
    else n_pass++;
    fx = 11'sd621; fvx = 4'sd3; force_xv();
    tick();
    n_checks++;
    if (FruitX !== 10'd624) $display("FAIL wall_right_edge: X=%0d want 624", FruitX);
    else n_pass++;
    fx = 11'sd2; fvx = -4'sd3; force_xv();
    tick();
    n_checks++;
    if (FruitX !== 10'd2) $display("FAIL wall_left_hold: X=%0d want 2", FruitX);
    else n_pass++;
    tick();
    n_checks++;
    if (FruitX !== 10'd5) $display("FAIL wall_left_after: X=%0d want 5", FruitX);
    else n_pass++;
    fx = 11'sd3; fvx = -4'sd3; force_xv();
    tick();
    n_checks++;
    if (FruitX !== 10'd0) $display("FAIL wall_left_edge: X=%0d want 0", FruitX);
    else n_pass++;
  endtask

  task automatic test_slice();
    int ex, evx, ey, s0, m0;
    launch();
    ex = lx; evx = lvx;
    for (int k = 1; k <= 10; k++) begin
      tick();
      x_step(ex, evx);
    end
    s0 = score_cnt; m0 = miss_cnt;
    pulse_slice();
    tick();
    n_checks++;
    if (score_pulse !== 1'b1 || Fruit_size !== 10'd8 || FruitY !== 10'd245 || FruitX !== 10'(ex))
      $display("FAIL slice_accept: sc=%b size=%0d Y=%0d X=%0d want 1/8/245/%0d",
               score_pulse, Fruit_size, FruitY, FruitX, ex);
    else n_pass++;
    @(posedge Clk); #1;
    n_checks++;
    if (score_pulse !== 1'b0) $display("FAIL score_one_clk: sc=%b want 0", score_pulse);
    else n_pass++;
    pulse_slice();
    for (int j = 1; j <= 47; j++) begin
      tick();
      ey = 245 - 18 * j + (j * (j - 1)) / 2;
      n_checks++;
      if (FruitY !== 10'(ey) || FruitX !== 10'(ex) || miss_pulse !== 1'b0)
        $display("FAIL sliced_fall %0d: X=%0d Y=%0d miss=%b want X=%0d Y=%0d miss=0",
                 j, FruitX, FruitY, miss_pulse, ex, ey);
      else n_pass++;
    end
    @(posedge Clk); #1;
    n_checks++;
    if (Fruit_size !== 10'd0 || fruit_active !== 1'b0 || score_cnt - s0 != 1 || miss_cnt != m0)
      $display("FAIL sliced_exit: size=%0d act=%b scores=%0d misses=%0d want 0/0/1/0",
               Fruit_size, fruit_active, score_cnt - s0, miss_cnt - m0);
    else n_pass++;
  endtask

  task automatic test_slice_at_exit();
    int m0;
    launch();
    repeat (56) tick();
    m0 = miss_cnt;
    pulse_slice();
    tick();
    n_checks++;
    if (score_pulse !== 1'b1 || miss_pulse !== 1'b0 || Fruit_size !== 10'd8 || FruitY !== 10'd452)
      $display("FAIL slice_at_exit: sc=%b miss=%b size=%0d Y=%0d want 1/0/8/452",
               score_pulse, miss_pulse, Fruit_size, FruitY);
    else n_pass++;
    tick();
    @(posedge Clk); #1;
    n_checks++;
    if (FruitY !== 10'd480 || Fruit_size !== 10'd0 || miss_cnt != m0)
      $display("FAIL slice_at_exit_done: Y=%0d size=%0d misses=%0d want 480/0/0",
               FruitY, Fruit_size, miss_cnt - m0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_flight();
    logic [1:0] st;
    launch();
    repeat (20) tick();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0;
    @(posedge Clk); #1;
    st = dut.state;
    n_checks++;
    if ({FruitX, FruitY, Fruit_size, fruit_active, score_pulse, miss_pulse} !== 33'd0)
      $display("FAIL midreset_outputs: X=%0d Y=%0d size=%0d act=%b sc=%b miss=%b want all 0",
               FruitX, FruitY, Fruit_size, fruit_active, score_pulse, miss_pulse);
    else n_pass++;
    n_checks++;
    if (st !== 2'd0 || dut.counter !== 7'd60 || dut.lfsr !== 16'hACE1)
      $display("FAIL midreset_state: state=%0d counter=%0d lfsr=%h want 0/60/ace1",
               st, dut.counter, dut.lfsr);
    else n_pass++;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (61) tick();
    n_checks++;
    if (FruitX !== 10'(first_lx) || FruitX !== 10'(64 + int'(pre_lfsr[8:0])) || Fruit_size !== 10'd16)
      $display("FAIL midreset_relaunch: X=%0d size=%0d want %0d/16", FruitX, Fruit_size, first_lx);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_launch_en_freeze();
    test_free_flight();
    test_wall();
    test_slice();
    test_slice_at_exit();
    test_reset_mid_flight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
